// File: rtl/regfile_piso.sv
// -----------------------------------------------------------------------------
// regfile_piso -- parallel-in / serial-out register file
//
// A RegSize x DataSize array. A parallel write stores BurstLen consecutive
// words in one cycle. A read burst then streams BurstLen consecutive words
// out, one per cycle, on a valid/ready serial port.
// All address arithmetic wraps modulo 2**AddrSize.
//
// Build option:
//   REGFILE_PISO_CLEAR_EN  defined   -> reset also clears every array word
//                          undefined -> the array is not reset
//   Control logic and outputs are reset in both builds.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   reg_enable_i     block enable; low aborts any burst and ignores commands
//   reg_write_i      parallel write strobe
//   write_addr_i     base address of the parallel write
//   write_data1_i..5 words for write_addr_i+0 .. +4
//   reg_read_i       start a serial read burst (accepted only when idle)
//   src_addr_i       base address of the serial read
//   src_ready_i      downstream consumer ready
//   src_out_o        serial data word (registered)
//   src_valid_o      src_out_o holds a valid beat
//   src_last_o       final beat of the burst
//   busy_o           burst in progress
// -----------------------------------------------------------------------------
module regfile_piso #(
   parameter int AddrSize = 7,
   parameter int DataSize = 32,
   parameter int RegSize  = 128,
   parameter int BurstLen = 5      // must match the number of write_data ports
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                reg_enable_i,
   input  logic                reg_write_i,
   input  logic [AddrSize-1:0] write_addr_i,
   input  logic [DataSize-1:0] write_data1_i,
   input  logic [DataSize-1:0] write_data2_i,
   input  logic [DataSize-1:0] write_data3_i,
   input  logic [DataSize-1:0] write_data4_i,
   input  logic [DataSize-1:0] write_data5_i,
   input  logic                reg_read_i,
   input  logic [AddrSize-1:0] src_addr_i,
   input  logic                src_ready_i,
   output logic [DataSize-1:0] src_out_o,
   output logic                src_valid_o,
   output logic                src_last_o,
   output logic                busy_o
);

   localparam int BeatW = $clog2(BurstLen);
   localparam logic [BeatW-1:0] LastBeat = BeatW'(BurstLen - 1);

   typedef enum logic {IDLE, BURST} state_e;

   state_e              state_q, state_d;
   logic [BeatW-1:0]    beat_q, beat_d;
   logic [AddrSize-1:0] base_q, base_d;
   logic [DataSize-1:0] out_q, out_d;
   logic                valid_q, valid_d;

   logic [DataSize-1:0] mem_q [RegSize];
   logic [DataSize-1:0] wdata [BurstLen];

   logic                wr_en;
   logic [AddrSize-1:0] next_addr;
   logic [AddrSize-1:0] wr_ofs [RegSize];
   logic                wr_hit [RegSize];

   assign wdata[0] = write_data1_i;
   assign wdata[1] = write_data2_i;
   assign wdata[2] = write_data3_i;
   assign wdata[3] = write_data4_i;
   assign wdata[4] = write_data5_i;

   assign wr_en     = reg_enable_i & reg_write_i;
   // Address of the beat that follows the current one, wrapping naturally.
   assign next_addr = base_q + AddrSize'(beat_q) + AddrSize'(1);

   // Each word decides for itself whether it falls inside the write window:
   // its distance above write_addr_i (mod 2**AddrSize) selects the data lane.
   for (genvar gi = 0; gi < RegSize; gi++) begin : g_wdec
      assign wr_ofs[gi] = AddrSize'(gi) - write_addr_i;
      assign wr_hit[gi] = wr_en && (wr_ofs[gi] < AddrSize'(BurstLen));
   end

`ifdef REGFILE_PISO_CLEAR_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int w = 0; w < RegSize; w++) mem_q[w] <= '0;
      end else begin
         for (int w = 0; w < RegSize; w++)
            if (wr_hit[w]) mem_q[w] <= wdata[wr_ofs[w][BeatW-1:0]];
      end
   end
`else
   always_ff @(posedge clk_i) begin
      for (int w = 0; w < RegSize; w++)
         if (wr_hit[w]) mem_q[w] <= wdata[wr_ofs[w][BeatW-1:0]];
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         beat_q  <= '0;
         base_q  <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         base_q  <= base_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   // Array reads below use pre-edge contents, so a beat loaded on the same
   // edge as a write to its address returns the old word.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      base_d  = base_q;
      out_d   = out_q;
      valid_d = valid_q;
      if (!reg_enable_i) begin
         state_d = IDLE;
         beat_d  = '0;
         out_d   = '0;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (reg_read_i) begin
                  state_d = BURST;
                  base_d  = src_addr_i;
                  beat_d  = '0;
                  out_d   = mem_q[src_addr_i];
                  valid_d = 1'b1;
               end
            end
            BURST: begin
               if (valid_q && src_ready_i) begin
                  if (beat_q == LastBeat) begin
                     state_d = IDLE;
                     beat_d  = '0;
                     out_d   = '0;
                     valid_d = 1'b0;
                  end else begin
                     beat_d  = beat_q + BeatW'(1);
                     out_d   = mem_q[next_addr];
                  end
               end
            end
         endcase
      end
   end

   assign src_out_o   = out_q;
   assign src_valid_o = valid_q;
   assign src_last_o  = valid_q && (beat_q == LastBeat);
   assign busy_o      = (state_q == BURST);

endmodule

// File: tb/tb_regfile_piso.sv
module tb_regfile_piso;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        reg_enable_i;
   logic        reg_write_i;
   logic [6:0]  write_addr_i;
   logic [31:0] write_data1_i, write_data2_i, write_data3_i, write_data4_i, write_data5_i;
   logic        reg_read_i;
   logic [6:0]  src_addr_i;
   logic        src_ready_i;
   logic [31:0] src_out_o;
   logic        src_valid_o;
   logic        src_last_o;
   logic        busy_o;

   always #5 clk_i = ~clk_i;

   regfile_piso dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .reg_enable_i  (reg_enable_i),
      .reg_write_i   (reg_write_i),
      .write_addr_i  (write_addr_i),
      .write_data1_i (write_data1_i),
      .write_data2_i (write_data2_i),
      .write_data3_i (write_data3_i),
      .write_data4_i (write_data4_i),
      .write_data5_i (write_data5_i),
      .reg_read_i    (reg_read_i),
      .src_addr_i    (src_addr_i),
      .src_ready_i   (src_ready_i),
      .src_out_o     (src_out_o),
      .src_valid_o   (src_valid_o),
      .src_last_o    (src_last_o),
      .busy_o        (busy_o)
   );

   typedef struct {
      logic            en, wr;
      logic [6:0]      wa;
      logic [4:0][31:0] d;
      logic            rd;
      logic [6:0]      sa;
      logic            rdy;
      logic [31:0]     eo;
      logic            ev, el, eb;
   } vec_t;

   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;
   logic [31:0] exp_rb [5];

   function automatic vec_t v(logic en, logic wr, logic [6:0] wa, logic [31:0] d0,
                              logic [31:0] dstep, logic rd, logic [6:0] sa, logic rdy,
                              logic [31:0] eo, logic ev, logic el, logic eb);
      vec_t r;
      r.en = en; r.wr = wr; r.wa = wa;
      for (int k = 0; k < 5; k++) r.d[k] = d0 + 32'(k) * dstep;
      r.rd = rd; r.sa = sa; r.rdy = rdy;
      r.eo = eo; r.ev = ev; r.el = el; r.eb = eb;
      return r;
   endfunction

   // Plain cycle: enabled, no commands, consumer ready.
   function automatic vec_t idl(logic [31:0] eo, logic ev, logic el, logic eb);
      return v(1, 0, 0, 0, 0, 0, 0, 1, eo, ev, el, eb);
   endfunction

   // Start a read burst at sa.
   function automatic vec_t rdv(logic [6:0] sa, logic [31:0] eo);
      return v(1, 0, 0, 0, 0, 1, sa, 1, eo, 1, 0, 1);
   endfunction

   task automatic chk(string name, int row, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
      end
   endtask

   task automatic drive(vec_t x);
      reg_enable_i  = x.en;
      reg_write_i   = x.wr;
      write_addr_i  = x.wa;
      write_data1_i = x.d[0];
      write_data2_i = x.d[1];
      write_data3_i = x.d[2];
      write_data4_i = x.d[3];
      write_data5_i = x.d[4];
      reg_read_i    = x.rd;
      src_addr_i    = x.sa;
      src_ready_i   = x.rdy;
   endtask

   task automatic check_outs(string tag, int row, logic [31:0] eo, logic ev, logic el, logic eb);
      chk({tag, ".src_out"},   row, src_out_o,   eo);
      chk({tag, ".src_valid"}, row, 32'(src_valid_o), 32'(ev));
      chk({tag, ".src_last"},  row, 32'(src_last_o),  32'(el));
      chk({tag, ".busy"},      row, 32'(busy_o),      32'(eb));
   endtask

   task automatic apply(vec_t x, string tag, int row);
      @(negedge clk_i);
      drive(x);
      @(posedge clk_i);
      #1;
      $display("%s row %0d: en=%0b wr=%0b rd=%0b sa=%0d rdy=%0b -> out=%h v=%0b l=%0b busy=%0b",
               tag, row, x.en, x.wr, x.rd, x.sa, x.rdy, src_out_o, src_valid_o, src_last_o, busy_o);
      check_outs(tag, row, x.eo, x.ev, x.el, x.eb);
   endtask

   initial begin
      // ---------------- vector table ----------------
      // zero burst at address 0
      tbl.push_back(rdv(0, 0));
      tbl.push_back(idl(0, 1, 0, 1));
      tbl.push_back(idl(0, 1, 0, 1));
      tbl.push_back(idl(0, 1, 0, 1));
      tbl.push_back(idl(0, 1, 1, 1));
      tbl.push_back(idl(0, 0, 0, 0));
      // write base 10, then read it back at full rate
      tbl.push_back(v(1, 1, 10, 32'h11, 32'h11, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(rdv(10, 32'h11));
      tbl.push_back(idl(32'h22, 1, 0, 1));
      tbl.push_back(idl(32'h33, 1, 0, 1));
      tbl.push_back(idl(32'h44, 1, 0, 1));
      tbl.push_back(idl(32'h55, 1, 1, 1));
      // reg_read on the edge that accepts the last beat is ignored
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0));
      // wrap-around: 126,127,0,1,2
      tbl.push_back(v(1, 1, 126, 32'hA0, 1, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(rdv(126, 32'hA0));
      tbl.push_back(idl(32'hA1, 1, 0, 1));
      tbl.push_back(idl(32'hA2, 1, 0, 1));
      tbl.push_back(idl(32'hA3, 1, 0, 1));
      tbl.push_back(idl(32'hA4, 1, 1, 1));
      tbl.push_back(idl(0, 0, 0, 0));
      // backpressure after beat 2, with a stray reg_read during the stall
      tbl.push_back(rdv(10, 32'h11));
      tbl.push_back(idl(32'h22, 1, 0, 1));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,   0, 32'h22, 1, 0, 1));
      tbl.push_back(v(1, 0, 0, 0, 0, 1, 126, 0, 32'h22, 1, 0, 1));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0,   0, 32'h22, 1, 0, 1));
      tbl.push_back(idl(32'h33, 1, 0, 1));
      tbl.push_back(idl(32'h44, 1, 0, 1));
      tbl.push_back(idl(32'h55, 1, 1, 1));
      tbl.push_back(idl(0, 0, 0, 0));
      // write base 12 on the edge that loads beat 3 (address 12)
      tbl.push_back(rdv(10, 32'h11));
      tbl.push_back(idl(32'h22, 1, 0, 1));
      tbl.push_back(v(1, 1, 12, 32'hBEEF0000, 1, 0, 0, 1, 32'h33, 1, 0, 1));
      tbl.push_back(idl(32'hBEEF0001, 1, 0, 1));
      tbl.push_back(idl(32'hBEEF0002, 1, 1, 1));
      tbl.push_back(idl(0, 0, 0, 0));
      // second burst sees the new data
      tbl.push_back(rdv(10, 32'h11));
      tbl.push_back(idl(32'h22, 1, 0, 1));
      tbl.push_back(idl(32'hBEEF0000, 1, 0, 1));
      tbl.push_back(idl(32'hBEEF0001, 1, 0, 1));
      tbl.push_back(idl(32'hBEEF0002, 1, 1, 1));
      tbl.push_back(idl(0, 0, 0, 0));
      // enable low mid-burst: abort, and the write/read on that edge are ignored
      tbl.push_back(rdv(10, 32'h11));
      tbl.push_back(idl(32'h22, 1, 0, 1));
      tbl.push_back(v(0, 1, 10, 32'hDEAD0000, 1, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(idl(0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0));
      tbl.push_back(rdv(10, 32'h11));
      tbl.push_back(idl(32'h22, 1, 0, 1));
      tbl.push_back(idl(32'hBEEF0000, 1, 0, 1));
      tbl.push_back(idl(32'hBEEF0001, 1, 0, 1));
      tbl.push_back(idl(32'hBEEF0002, 1, 1, 1));
      tbl.push_back(idl(0, 0, 0, 0));

      // ---------------- reset ----------------
      drive(idl(0, 0, 0, 0));
      rst_ni = 1'b0;
      #1;
      check_outs("reset", 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;

`ifndef REGFILE_PISO_CLEAR_EN
      // Array is not reset in this build: seed addresses 0..4 with zeros.
      apply(v(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "seed", 0);
`endif

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "vec", i);

      // ---------------- asynchronous reset mid-burst ----------------
      apply(rdv(10, 32'h11), "arst", 0);
      apply(idl(32'h22, 1, 0, 1), "arst", 1);
      #2;                      // clock is high, no edge pending for a while
      rst_ni = 1'b0;
      #1;
      $display("arst row 2: async reset -> out=%h v=%0b l=%0b busy=%0b",
               src_out_o, src_valid_o, src_last_o, busy_o);
      check_outs("arst", 2, 0, 0, 0, 0);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      apply(idl(0, 0, 0, 0), "arst", 3);

      // Read back base 10 after reset: cleared array or retained contents.
`ifdef REGFILE_PISO_CLEAR_EN
      for (int k = 0; k < 5; k++) exp_rb[k] = 32'h0;
`else
      exp_rb[0] = 32'h11; exp_rb[1] = 32'h22;
      exp_rb[2] = 32'hBEEF0000; exp_rb[3] = 32'hBEEF0001; exp_rb[4] = 32'hBEEF0002;
`endif
      apply(rdv(10, exp_rb[0]), "rback", 0);
      for (int k = 1; k < 5; k++) apply(idl(exp_rb[k], 1, (k == 4), 1), "rback", k);
      apply(idl(0, 0, 0, 0), "rback", 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard bound on run time in case the bench itself stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_piso.md
# regfile_piso

Parallel-in / serial-out register file: a 128 x 32-bit array that accepts a 5-word burst in one cycle on a wide write port. It streams any 5 consecutive words out one per cycle on a valid/ready serial port. It is the complement of the team's serial-in / parallel-out register file. It feeds downstream single-word consumers that apply backpressure.

## Interface
Parameters:
- AddrSize, 7, address width; array depth is 2**AddrSize
- DataSize, 32, word width
- RegSize, 128, number of words
- BurstLen, 5, words per parallel write and per serial read burst

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- reg_enable  in  1  block enable; low forces the serial port idle and ignores commands
- reg_write  in  1  parallel write strobe (qualified by reg_enable)
- write_addr  in  AddrSize  base address of parallel write
- write_data1..write_data5  in  DataSize each  words for write_addr+0..+4
- reg_read  in  1  serial read start strobe (qualified by reg_enable)
- src_addr  in  AddrSize  base address of serial read, sampled on the start edge
- src_ready  in  1  consumer ready
- src_out  out  DataSize  serial data word (registered)
- src_valid  out  1  src_out holds a valid beat
- src_last  out  1  high with the final (5th) beat
- busy  out  1  burst in progress (state BURST)

## Operation
- States: IDLE, BURST. Beat counter 0..BurstLen-1 and base address register.
- Parallel write:
  - When reg_enable&reg_write, the edge writes REG[(write_addr+k) mod 128] <= write_datak+1 for k=0..4.
  - Accepted in any state.
- Read start:
  - When in IDLE and reg_enable&reg_read, the edge latches base <= src_addr, sets beat=0, and goes to BURST.
  - The same edge loads src_out <= REG[src_addr] and sets src_valid=1.
  - reg_read in BURST is ignored (no queueing).
- Advance:
  - An edge with src_valid&src_ready and beat<4 increments beat and loads src_out <= REG[(base+beat+1) mod 128].
  - With src_ready low, src_out, src_valid and src_last hold unchanged.
- Finish: an edge with src_valid&src_ready and beat==4 clears src_valid, src_last and src_out, and returns to IDLE.
- src_last = src_valid & (beat==4).
- Address arithmetic is AddrSize-bit modulo; base 126 reads 126,127,0,1,2.
- Read/write collision:
  - Every array read samples pre-edge contents.
  - A write on the same edge as a beat load to that address yields old data on that beat.
  - Later beats see the new data.
- reg_enable low in any state: the next edge forces IDLE, src_out=0, src_valid=0, src_last=0. The aborted burst is discarded. Writes are ignored.

## Timing
- Reset (asynchronous, immediate):
  - src_out=0, src_valid=0, src_last=0, busy=0, state IDLE, beat=0, base=0.
  - The array follows Configuration.
- Read latency: first beat valid the cycle after the reg_read edge (1 cycle).
- Throughput: 1 word/cycle with src_ready held high; a 5-beat burst occupies 5 cycles.
- Minimum start-to-start: 6 cycles; a new reg_read is accepted from the cycle after the last beat is accepted.
- Parallel write visible to reads sampled on the following edge onward.
- Reset asserted mid-burst: outputs clear immediately. No partial beat is presented after rst releases.

## Configuration
- REGFILE_PISO_CLEAR_EN defined: reset also clears all 128 words to 0.
- REGFILE_PISO_CLEAR_EN undefined: the array is not reset (contents X until written); control and outputs still reset as above.
- Serial and write behaviour are identical in both builds.

## Test plan
- Reset with REGFILE_PISO_CLEAR_EN, then read at src_addr=0 with src_ready=1 -> five beats of 0x00000000, src_last on beat 5, busy low the next cycle.
- Write base 10 with 0x11,0x22,0x33,0x44,0x55, then read at 10 with src_ready=1 -> src_out 0x11..0x55 on consecutive cycles, first beat 1 cycle after start.
- Write base 126 with 0xA0..0xA4, then read at 126 -> beats 0xA0,0xA1,0xA2,0xA3,0xA4 from addresses 126,127,0,1,2.
- Read at 10, drop src_ready for 3 cycles after beat 2 -> beat 2 (0x22) held stable with src_valid=1. The burst resumes 0x33 after ready returns. A reg_read pulse during the burst is ignored.
- Mid-burst, write base 12 with 0xBEEF.. on the edge that loads beat 3 (addr 12) -> beat 3 shows old 0x33. A second burst at 10 then shows 0xBEEF at beat 3.
- Mid-burst, pull reg_enable low for one cycle -> src_valid=0 and src_out=0 the next cycle, busy=0. Assert rst low mid-burst -> outputs clear asynchronously without waiting for a clock edge.
